// File: rtl/mem_stage_ls_pkg.sv
// Shared types for the EX/MEM load/store stage: access sizes, FSM states, redirect codes.
// No logic here; imported by the stage top and the lane-alignment helper.
package mem_stage_ls_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_WORD_X = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } ls_state_t;

    localparam logic [1:0] J_NONE      = 2'b00;
    localparam logic [1:0] J_REG       = 2'b11;
    localparam logic [1:0] PC_SEQ      = 2'b00;
    localparam logic [1:0] PC_REDIRECT = 2'b01;

endpackage

// File: rtl/mem_stage_ls_if.sv
// Data-memory port: valid/ready request channel plus a valid-only response channel.
// The stage holds every request field stable from valid until ready.
interface mem_stage_ls_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, we, addr, be, wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, we, addr, be, wdata,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/mem_stage_ls_align.sv
// Byte-lane steering: store byte enables/replicated data, misalign check, load extraction/extension.
// Purely combinational, zero latency, no backpressure.
module mem_stage_ls_align
    import mem_stage_ls_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  mem_size_t         st_size,
    input  logic [LANE_W-1:0] st_lane,
    input  logic [DATA_W-1:0] st_data,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_wdata,
    output logic              st_misalign,
    input  mem_size_t         ld_size,
    input  logic              ld_unsigned,
    input  logic [LANE_W-1:0] ld_lane,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [DATA_W-1:0] ld_data
);

    logic [LANE_W-1:0] lane_h;
    logic [LANE_W-1:0] lane_w;
    logic [DATA_W-1:0] shifted;

    assign lane_h  = st_lane & ~LANE_W'(1);
    assign lane_w  = st_lane & ~LANE_W'(3);
    assign shifted = ld_raw >> {ld_lane, 3'b000};

    // A word is always 4 bytes; on wider buses it occupies a 4-byte-aligned slot.
    always_comb begin
        st_be       = '0;
        st_wdata    = '0;
        st_misalign = 1'b0;
        case (st_size)
            SIZE_BYTE: begin
                st_be    = BE_W'(1) << st_lane;
                st_wdata = {BE_W{st_data[7:0]}};
            end
            SIZE_HALF: begin
                st_be       = BE_W'(3) << lane_h;
                st_wdata    = {(BE_W / 2){st_data[15:0]}};
                st_misalign = st_lane[0];
            end
            default: begin
                st_be       = BE_W'(15) << lane_w;
                st_wdata    = {(BE_W / 4){st_data[31:0]}};
                st_misalign = (st_lane[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        ld_data = '0;
        case (ld_size)
            SIZE_BYTE: ld_data = ld_unsigned ? DATA_W'(shifted[7:0])
                                             : DATA_W'($signed(shifted[7:0]));
            SIZE_HALF: ld_data = ld_unsigned ? DATA_W'(shifted[15:0])
                                             : DATA_W'($signed(shifted[15:0]));
            default:   ld_data = ld_unsigned ? DATA_W'(shifted[31:0])
                                             : DATA_W'($signed(shifted[31:0]));
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// EX/MEM stage: branch/jump redirect, M register, sized loads/stores over a valid/ready memory port.
// Store stalls >=1 cycle, load >=2; req_ready and rsp_valid delays extend the stall one-for-one.
module mem_stage_ls
    import mem_stage_ls_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_e,
    input  logic              mem_to_reg_e,
    input  logic              mem_write_e,
    input  logic [1:0]        mem_size_e,
    input  logic              mem_unsigned_e,
    input  logic              branch_e,
    input  logic              zero_e,
    input  logic [1:0]        j_inst_e,
    input  logic [DATA_W-1:0] alu_out_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [ADDR_W-1:0] pc_branch_e,
    input  logic [ADDR_W-1:0] jump_addr_e,
    input  logic              flush_m,
    mem_stage_ls_if.master    dmem,
    output logic              stall,
    output logic [1:0]        if_pc_src,
    output logic [ADDR_W-1:0] if_pc_branch_in,
    output logic [DATA_W-1:0] read_data_m,
    output logic [DATA_W-1:0] alu_out_m,
    output logic [REG_AW-1:0] write_reg_m,
    output logic              reg_write_m,
    output logic              mem_to_reg_m,
    output logic              misalign_m
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    mem_size_t         size_e;
    mem_size_t         size_m;
    logic              uns_m;
    logic              mem_write_m;
    logic [LANE_W-1:0] lane_m;
    logic [BE_W-1:0]   be_e;
    logic [BE_W-1:0]   be_m;
    logic [DATA_W-1:0] wdata_e;
    logic [DATA_W-1:0] wdata_m;
    logic [ADDR_W-1:0] addr_e;
    logic [ADDR_W-1:0] addr_m;
    logic [DATA_W-1:0] ld_ext;
    logic              mis_raw;
    logic              mem_e;
    logic              mis_e;
    logic              start;
    ls_state_t         state;
    logic              stall_q;
    logic              req_valid_q;

    assign size_e = mem_size_t'(mem_size_e);
    assign addr_e = ADDR_W'(alu_out_e) & ~ADDR_W'(BE_W - 1);
    assign mem_e  = mem_to_reg_e | mem_write_e;
    assign mis_e  = mem_e & mis_raw;
    assign start  = !stall_q && !flush_m && mem_e && !mis_e;

    mem_stage_ls_align #(.DATA_W(DATA_W)) u_align (
        .st_size     (size_e),
        .st_lane     (alu_out_e[LANE_W-1:0]),
        .st_data     (write_data_e),
        .st_be       (be_e),
        .st_wdata    (wdata_e),
        .st_misalign (mis_raw),
        .ld_size     (size_m),
        .ld_unsigned (uns_m),
        .ld_lane     (lane_m),
        .ld_raw      (dmem.rsp_data),
        .ld_data     (ld_ext)
    );

    // Redirect is suppressed while stalled: EX is frozen and will present again.
    always_comb begin
        if_pc_src       = PC_SEQ;
        if_pc_branch_in = '0;
        if (!stall_q) begin
            if (zero_e && branch_e) begin
                if_pc_src       = PC_REDIRECT;
                if_pc_branch_in = pc_branch_e;
            end else if (j_inst_e == J_REG) begin
                if_pc_src       = PC_REDIRECT;
                if_pc_branch_in = ADDR_W'(alu_out_e);
            end else if (j_inst_e != J_NONE) begin
                if_pc_src       = PC_REDIRECT;
                if_pc_branch_in = jump_addr_e;
            end
        end
    end

    // M register; request fields are captured here so they stay stable through REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            misalign_m   <= 1'b0;
            write_reg_m  <= '0;
            alu_out_m    <= '0;
            size_m       <= SIZE_BYTE;
            uns_m        <= 1'b0;
            lane_m       <= '0;
            addr_m       <= '0;
            be_m         <= '0;
            wdata_m      <= '0;
        end else if (!stall_q) begin
            if (flush_m) begin
                reg_write_m  <= 1'b0;
                mem_to_reg_m <= 1'b0;
                mem_write_m  <= 1'b0;
                misalign_m   <= 1'b0;
                write_reg_m  <= '0;
                alu_out_m    <= '0;
                size_m       <= SIZE_BYTE;
                uns_m        <= 1'b0;
                lane_m       <= '0;
                addr_m       <= '0;
                be_m         <= '0;
                wdata_m      <= '0;
            end else begin
                reg_write_m  <= reg_write_e & ~mis_e;
                mem_to_reg_m <= mem_to_reg_e;
                mem_write_m  <= mem_write_e;
                misalign_m   <= mis_e;
                write_reg_m  <= write_reg_e;
                alu_out_m    <= alu_out_e;
                size_m       <= size_e;
                uns_m        <= mem_unsigned_e;
                lane_m       <= alu_out_e[LANE_W-1:0];
                addr_m       <= addr_e;
                be_m         <= be_e;
                wdata_m      <= wdata_e;
            end
        end
    end

    // stall_q and req_valid_q are registered alongside state so they always match it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            stall_q     <= 1'b0;
            req_valid_q <= 1'b0;
            read_data_m <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ;
                        stall_q     <= 1'b1;
                        req_valid_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (dmem.req_ready) begin
                        req_valid_q <= 1'b0;
                        if (mem_write_m) begin
                            state   <= IDLE;
                            stall_q <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.rsp_valid) begin
                        read_data_m <= ld_ext;
                        state       <= IDLE;
                        stall_q     <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    stall_q     <= 1'b0;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall          = stall_q;
    assign dmem.req_valid = req_valid_q;
    assign dmem.we        = mem_write_m;
    assign dmem.addr      = addr_m;
    assign dmem.be        = be_m;
    assign dmem.wdata     = wdata_m;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Bench for mem_stage_ls: reactive memory model with programmable ready/response delays,
// request and load-data scoreboards, redirect and reset-during-access checks.
module tb_mem_stage_ls;

    logic        clk;
    logic        rst;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_unsigned_e;
    logic [1:0]  mem_size_e, j_inst_e;
    logic        branch_e, zero_e, flush_m;
    logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
    logic [4:0]  write_reg_e;
    logic        stall;
    logic [1:0]  if_pc_src;
    logic [31:0] if_pc_branch_in, read_data_m, alu_out_m;
    logic [4:0]  write_reg_m;
    logic        reg_write_m, mem_to_reg_m, misalign_m;

    mem_stage_ls_if #(.DATA_W(32), .ADDR_W(32)) dmem ();

    mem_stage_ls #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
        .mem_size_e(mem_size_e), .mem_unsigned_e(mem_unsigned_e),
        .branch_e(branch_e), .zero_e(zero_e), .j_inst_e(j_inst_e),
        .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
        .pc_branch_e(pc_branch_e), .jump_addr_e(jump_addr_e), .flush_m(flush_m),
        .dmem(dmem),
        .stall(stall), .if_pc_src(if_pc_src), .if_pc_branch_in(if_pc_branch_in),
        .read_data_m(read_data_m), .alu_out_m(alu_out_m), .write_reg_m(write_reg_m),
        .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .misalign_m(misalign_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        string     tag;
        bit        ld, st;
        bit [1:0]  size;
        bit        uns, flush;
        bit [31:0] addr, sdata, rsp;
        int        rdy_d, rsp_d;
        bit        exp_req;
        bit [3:0]  exp_be;
        bit [31:0] exp_wd, exp_rd;
        int        exp_stall;
        bit        exp_mis;
    } op_t;

    req_t        req_q[$];
    logic [31:0] rd_q[$];
    op_t         ops[$];

    int n_tests = 0;
    int n_fail  = 0;
    int accepts = 0;

    int          rdy_delay = 0;
    int          rsp_delay = 0;
    logic [31:0] rsp_word  = '0;
    bit          req_active = 0;
    bit          rsp_pend   = 0;
    int          wait_cnt   = 0;
    int          rsp_cnt    = 0;
    logic [31:0] first_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: ready after rdy_delay waiting cycles, response rsp_delay cycles into WAIT.
    initial begin
        dmem.req_ready = 1'b0;
        dmem.rsp_valid = 1'b0;
        dmem.rsp_data  = '0;
        forever begin
            @(negedge clk);
            dmem.rsp_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_cnt >= rsp_delay) begin
                    dmem.rsp_valid = 1'b1;
                    dmem.rsp_data  = rsp_word;
                    rsp_pend       = 0;
                end else begin
                    rsp_cnt++;
                end
            end
            dmem.req_ready = 1'b0;
            if (dmem.req_valid === 1'b1) begin
                if (!req_active) begin
                    req_active = 1;
                    first_addr = dmem.addr;
                    wait_cnt   = 0;
                end
                if (wait_cnt >= rdy_delay) begin
                    dmem.req_ready = 1'b1;
                    req_active     = 0;
                    accepts++;
                    check("req_addr_stable", dmem.addr, first_addr);
                    if (req_q.size() == 0) begin
                        check("req_unexpected", 1, 0);
                    end else begin
                        req_t e;
                        e = req_q.pop_front();
                        check("req_we", dmem.we, e.we);
                        check("req_addr", dmem.addr, e.addr);
                        check("req_be", dmem.be, e.be);
                        if (e.we) check("req_wdata", dmem.wdata, e.wdata);
                    end
                    if (!dmem.we) begin
                        rsp_pend = 1;
                        rsp_cnt  = 0;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic ex_nop();
        reg_write_e = 0; mem_to_reg_e = 0; mem_write_e = 0; mem_unsigned_e = 0;
        mem_size_e = 2'b00; j_inst_e = 2'b00; branch_e = 0; zero_e = 0; flush_m = 0;
        alu_out_e = '0; write_data_e = '0; write_reg_e = '0;
        pc_branch_e = '0; jump_addr_e = '0;
    endtask

    function automatic op_t mk(string tag, bit ld, bit st, bit [1:0] size, bit uns, bit flush,
                               bit [31:0] addr, bit [31:0] sdata, bit [31:0] rsp,
                               int rdy_d, int rsp_d, bit exp_req, bit [3:0] exp_be,
                               bit [31:0] exp_wd, bit [31:0] exp_rd, int exp_stall, bit exp_mis);
        op_t o;
        o.tag = tag; o.ld = ld; o.st = st; o.size = size; o.uns = uns; o.flush = flush;
        o.addr = addr; o.sdata = sdata; o.rsp = rsp; o.rdy_d = rdy_d; o.rsp_d = rsp_d;
        o.exp_req = exp_req; o.exp_be = exp_be; o.exp_wd = exp_wd; o.exp_rd = exp_rd;
        o.exp_stall = exp_stall; o.exp_mis = exp_mis;
        return o;
    endfunction

    // Called at a negedge with the stage idle; returns at a negedge.
    task automatic do_op(input op_t op);
        int   n;
        int   acc0;
        logic exp_rw;
        rdy_delay = op.rdy_d; rsp_delay = op.rsp_d; rsp_word = op.rsp;
        reg_write_e = op.ld; mem_to_reg_e = op.ld; mem_write_e = op.st;
        mem_size_e = op.size; mem_unsigned_e = op.uns; flush_m = op.flush;
        alu_out_e = op.addr; write_data_e = op.sdata; write_reg_e = 5'd9;
        if (op.exp_req) req_q.push_back(req_t'{op.st, op.addr & ~32'h3, op.exp_be, op.exp_wd});
        if (op.ld && op.exp_req) rd_q.push_back(op.exp_rd);
        acc0 = accepts;
        @(posedge clk); #1;
        ex_nop();
        exp_rw = op.ld && !op.exp_mis && !op.flush;
        check({op.tag, "_misalign"}, misalign_m, op.exp_mis);
        check({op.tag, "_reg_write"}, reg_write_m, exp_rw);
        check({op.tag, "_alu_out"}, alu_out_m, op.flush ? 32'h0 : op.addr);
        n = 0;
        while (stall && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({op.tag, "_stall_cycles"}, n, op.exp_stall);
        check({op.tag, "_accepts"}, accepts - acc0, op.exp_req ? 1 : 0);
        if (op.ld && op.exp_req) begin
            if (rd_q.size() == 0) check({op.tag, "_rd_queue"}, 0, 1);
            else check({op.tag, "_read_data"}, read_data_m, rd_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lane;
        int          rspd;
        bit          u;
        logic [31:0] d;
        logic [31:0] sh;
        logic [31:0] exp;

        ex_nop();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_req_valid", dmem.req_valid, 0);
        check("rst_read_data", read_data_m, 0);
        check("rst_reg_write", reg_write_m, 0);
        check("rst_pc_src", if_pc_src, 0);
        rst = 1'b1;
        @(negedge clk);

        //            tag    ld st sz  u  fl addr       sdata         rsp            rdy rsp req be       wdata          rdata          stl mis
        ops.push_back(mk("sw",   0, 1, 2, 0, 0, 32'h100, 32'hDEADBEEF, 32'h0,          0, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,          1, 0));
        ops.push_back(mk("sb",   0, 1, 0, 0, 0, 32'h103, 32'h000000A5, 32'h0,          0, 0, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,          1, 0));
        ops.push_back(mk("sh",   0, 1, 1, 0, 0, 32'h102, 32'h00001234, 32'h0,          0, 0, 1, 4'b1100, 32'h12341234, 32'h0,          1, 0));
        ops.push_back(mk("sw11", 0, 1, 3, 0, 0, 32'h10C, 32'hCAFEF00D, 32'h0,          1, 0, 1, 4'b1111, 32'hCAFEF00D, 32'h0,          2, 0));
        ops.push_back(mk("lb",   1, 0, 0, 0, 0, 32'h103, 32'h0,        32'hA5000000,   0, 0, 1, 4'b1000, 32'h0,        32'hFFFFFFA5,   2, 0));
        ops.push_back(mk("lbu",  1, 0, 0, 1, 0, 32'h103, 32'h0,        32'hA5000000,   0, 0, 1, 4'b1000, 32'h0,        32'h000000A5,   2, 0));
        ops.push_back(mk("lbp",  1, 0, 0, 0, 0, 32'h101, 32'h0,        32'h00007F00,   0, 0, 1, 4'b0010, 32'h0,        32'h0000007F,   2, 0));
        ops.push_back(mk("lh",   1, 0, 1, 0, 0, 32'h102, 32'h0,        32'h80010000,   0, 0, 1, 4'b1100, 32'h0,        32'hFFFF8001,   2, 0));
        ops.push_back(mk("lhu",  1, 0, 1, 1, 0, 32'h102, 32'h0,        32'h80010000,   0, 0, 1, 4'b1100, 32'h0,        32'h00008001,   2, 0));
        ops.push_back(mk("lw",   1, 0, 2, 0, 0, 32'h104, 32'h0,        32'h12345678,   3, 1, 1, 4'b1111, 32'h0,        32'h12345678,   6, 0));
        ops.push_back(mk("lwmis",1, 0, 2, 0, 0, 32'h101, 32'h0,        32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,          0, 1));
        ops.push_back(mk("shmis",0, 1, 1, 0, 0, 32'h101, 32'h0000BEEF, 32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,          0, 1));
        ops.push_back(mk("lwfl", 1, 0, 2, 0, 1, 32'h108, 32'h0,        32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,          0, 0));
        foreach (ops[i]) do_op(ops[i]);

        for (int i = 0; i < 6; i++) begin
            lane = $urandom_range(0, 3);
            rspd = $urandom_range(0, 2);
            u    = 1'($urandom_range(0, 1));
            d    = $urandom;
            sh   = d >> (8 * lane);
            exp  = u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            do_op(mk("rlb", 1, 0, 0, u, 0, 32'h200 | 32'(lane), 32'h0, d, 0, rspd,
                     1, 4'(4'b0001 << lane), 32'h0, exp, 2 + rspd, 0));
        end

        // Redirect priority with the stage idle.
        branch_e = 1; zero_e = 1; j_inst_e = 2'b11;
        pc_branch_e = 32'h40; alu_out_e = 32'h80; jump_addr_e = 32'h200;
        #1;
        check("br_src", if_pc_src, 2'b01);
        check("br_tgt", if_pc_branch_in, 32'h40);
        zero_e = 0; #1;
        check("jr_src", if_pc_src, 2'b01);
        check("jr_tgt", if_pc_branch_in, 32'h80);
        j_inst_e = 2'b01; #1;
        check("j01_tgt", if_pc_branch_in, 32'h200);
        j_inst_e = 2'b10; #1;
        check("j10_tgt", if_pc_branch_in, 32'h200);
        j_inst_e = 2'b00; #1;
        check("seq_src", if_pc_src, 2'b00);
        check("seq_tgt", if_pc_branch_in, 32'h0);
        ex_nop();
        @(negedge clk);

        // Same branch presented while a store holds the stall.
        rdy_delay = 2;
        req_q.push_back(req_t'{1'b1, 32'h120, 4'hF, 32'h0BADF00D});
        mem_write_e = 1; mem_size_e = 2'b10; alu_out_e = 32'h120; write_data_e = 32'h0BADF00D;
        @(posedge clk); #1;
        ex_nop();
        branch_e = 1; zero_e = 1; j_inst_e = 2'b11; pc_branch_e = 32'h40;
        #1;
        check("stl_stall", stall, 1);
        check("stl_src", if_pc_src, 2'b00);
        check("stl_tgt", if_pc_branch_in, 32'h0);
        ex_nop();
        n = 0;
        while (stall && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("stl_stall_cycles", n, 3);
        @(negedge clk);

        // Reset while waiting for load data; the late response must be discarded.
        rdy_delay = 0; rsp_delay = 4; rsp_word = 32'h5555AAAA;
        req_q.push_back(req_t'{1'b0, 32'h110, 4'hF, 32'h0});
        reg_write_e = 1; mem_to_reg_e = 1; mem_size_e = 2'b10; alu_out_e = 32'h110; write_reg_e = 5'd3;
        @(posedge clk); #1;
        ex_nop();
        @(posedge clk); #1;
        check("wait_stall", stall, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_stall", stall, 0);
        check("arst_req_valid", dmem.req_valid, 0);
        check("arst_reg_write", reg_write_m, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("late_rsp_read_data", read_data_m, 0);
        check("late_rsp_stall", stall, 0);
        check("late_rsp_req_valid", dmem.req_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
